// File: rtl/fb_sequencer.sv
// Double-buffer framebuffer sequencer: swap, clear, render handoff.
// Owns the single framebuffer write port shared by clear engine and renderer.
module fb_sequencer #(
  parameter int FB_PIXELS = 57600,
  parameter int ADDRW = 16,
  parameter int DATAW = 4,
  parameter logic [DATAW-1:0] CLEAR_COLR = '0,
  parameter int DRAIN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             frame,
  output logic             render_start,
  input  logic             render_done,
  input  logic             rnd_we,
  input  logic [ADDRW-1:0] rnd_addr,
  input  logic [DATAW-1:0] rnd_colr,
  output logic             fb_we_0,
  output logic             fb_we_1,
  output logic [ADDRW-1:0] fb_addr,
  output logic [DATAW-1:0] fb_colr,
  output logic             fb_front,
  output logic             busy,
  output logic [7:0]       frames_dropped,
  output logic             wr_err
);

  localparam int DN = (DRAIN < 1) ? 1 : DRAIN;
  localparam int DW = $clog2(DN + 1);
  localparam logic [ADDRW-1:0] LAST = ADDRW'(FB_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_CLEAR,
    S_START,
    S_DRAW,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDRW-1:0] clr_cnt;
  logic [DW-1:0]    drn_cnt;
  logic             clr_last;
  logic             drn_last;

  logic             rnd_ok;
  logic             we_d;
  logic [ADDRW-1:0] addr_d;
  logic [DATAW-1:0] colr_d;
  logic             we_q;

  assign clr_last = (clr_cnt == LAST);
  assign drn_last = (drn_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (frame && en) state_nx = S_SWAP;
      end
      S_SWAP: state_nx = S_CLEAR;
      S_CLEAR: begin
        if (clr_last) state_nx = S_START;
      end
      S_START: state_nx = S_DRAW;
      S_DRAW: begin
        if (render_done) state_nx = S_DONE;
      end
      S_DONE: begin
        if (drn_last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    render_start = (state == S_START);
    busy         = (state != S_IDLE);
    rnd_ok       = (state == S_DRAW) || (state == S_DONE);
    we_d         = 1'b0;
    addr_d       = rnd_addr;
    colr_d       = rnd_colr;
    unique case (1'b1)
      (state == S_CLEAR): begin
        we_d   = 1'b1;
        addr_d = clr_cnt;
        colr_d = CLEAR_COLR;
      end
      rnd_ok: begin
        we_d = rnd_we;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt  <= '0;
      drn_cnt  <= '0;
      fb_front <= 1'b0;
    end else begin
      if (state == S_SWAP) begin
        fb_front <= ~fb_front;
        clr_cnt  <= '0;
      end else if (state == S_CLEAR && !clr_last) begin
        clr_cnt <= clr_cnt + ADDRW'(1);
      end
      if (state == S_DRAW && render_done) begin
        drn_cnt <= DW'(DN - 1);
      end else if (state == S_DONE && !drn_last) begin
        drn_cnt <= drn_cnt - DW'(1);
      end
    end
  end

  // Address/colour hold their last value on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      fb_addr <= '0;
      fb_colr <= '0;
    end else begin
      we_q <= we_d;
      if (we_d) begin
        fb_addr <= addr_d;
        fb_colr <= colr_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_dropped <= '0;
      wr_err         <= 1'b0;
    end else begin
      if (frame && state != S_IDLE && frames_dropped != 8'hff) begin
        frames_dropped <= frames_dropped + 8'd1;
      end
      if (rnd_we && !rnd_ok) begin
        wr_err <= 1'b1;
      end
    end
  end

  assign fb_we_0 = we_q & fb_front;
  assign fb_we_1 = we_q & ~fb_front;

endmodule

// File: tb/tb_fb_sequencer.sv
// Scoreboard bench for fb_sequencer: clear/render write stream,
// drop counting, rejected writes, enable gating and async reset.
module tb_fb_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        frame;
  logic        render_start;
  logic        render_done;
  logic        rnd_we;
  logic [15:0] rnd_addr;
  logic [3:0]  rnd_colr;
  logic        fb_we_0;
  logic        fb_we_1;
  logic [15:0] fb_addr;
  logic [3:0]  fb_colr;
  logic        fb_front;
  logic        busy;
  logic [7:0]  frames_dropped;
  logic        wr_err;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [3:0]  colr;
  } wr_t;

  wr_t q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  fb_sequencer #(
    .FB_PIXELS(16),
    .ADDRW(16),
    .DATAW(4),
    .CLEAR_COLR(4'h0),
    .DRAIN(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .frame(frame),
    .render_start(render_start),
    .render_done(render_done),
    .rnd_we(rnd_we),
    .rnd_addr(rnd_addr),
    .rnd_colr(rnd_colr),
    .fb_we_0(fb_we_0),
    .fb_we_1(fb_we_1),
    .fb_addr(fb_addr),
    .fb_colr(fb_colr),
    .fb_front(fb_front),
    .busy(busy),
    .frames_dropped(frames_dropped),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 2'b01 -> buffer 0, 2'b10 -> buffer 1
  task automatic push_clear(input logic [1:0] sel);
    for (int i = 0; i < 16; i++) begin
      q.push_back('{sel: sel, addr: 16'(i), colr: 4'h0});
    end
  endtask

  always @(negedge clk) begin
    if (fb_we_0 || fb_we_1) begin
      if (q.size() == 0) begin
        check("we_unexp", 32'(fb_addr), 32'hffff_ffff);
      end else begin
        wr_t e;
        e = q.pop_front();
        check("we_sel", 32'({fb_we_1, fb_we_0}), 32'(e.sel));
        check("we_addr", 32'(fb_addr), 32'(e.addr));
        check("we_colr", 32'(fb_colr), 32'(e.colr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    rst_n       = 1'b0;
    en          = 1'b1;
    frame       = 1'b0;
    render_done = 1'b0;
    rnd_we      = 1'b0;
    rnd_addr    = '0;
    rnd_colr    = '0;

    for (int i = 0; i < 4; i++) begin
      frame = ~frame;
      tick();
    end
    frame = 1'b0;
    check("rst_we", 32'({fb_we_1, fb_we_0}), 0);
    check("rst_addr", 32'(fb_addr), 0);
    check("rst_colr", 32'(fb_colr), 0);
    check("rst_front", 32'(fb_front), 0);
    check("rst_start", 32'(render_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(frames_dropped), 0);
    check("rst_err", 32'(wr_err), 0);
    rst_n = 1'b1;
    tick();

    // full sequence into buffer 0
    frame = 1'b1;
    push_clear(2'b01);
    tick();
    frame = 1'b0;
    check("swap_busy", 32'(busy), 1);
    check("swap_front", 32'(fb_front), 0);
    tick();
    check("t2_front", 32'(fb_front), 1);
    check("t2_we", 32'({fb_we_1, fb_we_0}), 0);
    tick();
    check("t3_we0", 32'(fb_we_0), 1);
    check("t3_addr", 32'(fb_addr), 0);
    repeat (14) tick();
    check("t17_start", 32'(render_start), 0);
    tick();
    check("t18_start", 32'(render_start), 1);
    tick();
    check("t19_start", 32'(render_start), 0);
    check("clr_done", q.size(), 0);

    for (int i = 0; i < 5; i++) begin
      rnd_we   = 1'b1;
      rnd_addr = 16'(100 + 7 * i);
      rnd_colr = 4'(i + 1);
      q.push_back('{sel: 2'b01, addr: rnd_addr, colr: rnd_colr});
      tick();
    end
    rnd_we = 1'b0;
    tick();
    check("rnd_done", q.size(), 0);

    for (int i = 0; i < 3; i++) begin
      frame = 1'b1;
      tick();
      frame = 1'b0;
      tick();
    end
    check("ovr_drop", 32'(frames_dropped), 3);
    check("ovr_front", 32'(fb_front), 1);
    check("ovr_busy", 32'(busy), 1);

    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    check("done_d1", 32'(busy), 1);
    tick();
    check("done_d2", 32'(busy), 1);
    tick();
    check("done_d3", 32'(busy), 1);
    tick();
    check("done_d4", 32'(busy), 0);

    // rejected write in IDLE
    rnd_we   = 1'b1;
    rnd_addr = 16'h0055;
    rnd_colr = 4'h7;
    tick();
    rnd_we = 1'b0;
    tick();
    check("idle_err", 32'(wr_err), 1);

    en    = 1'b0;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check("en_busy", 32'(busy), 0);
    tick();
    check("en_busy2", 32'(busy), 0);
    check("en_drop", 32'(frames_dropped), 3);
    check("en_front", 32'(fb_front), 1);
    en = 1'b1;

    // second frame into buffer 1, renderer writes during CLEAR rejected
    frame = 1'b1;
    push_clear(2'b10);
    tick();
    frame = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      rnd_we   = 1'b1;
      rnd_addr = 16'h0005;
      rnd_colr = 4'h9;
      tick();
    end
    rnd_we = 1'b0;
    repeat (14) tick();
    check("clr2_done", q.size(), 0);
    check("clr2_front", 32'(fb_front), 0);
    check("clr2_err", 32'(wr_err), 1);

    for (int i = 0; i < 300; i++) begin
      frame = 1'b1;
      tick();
      frame = 1'b0;
      tick();
    end
    check("sat_drop", 32'(frames_dropped), 255);
    check("sat_front", 32'(fb_front), 0);

    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    repeat (3) tick();
    check("done2_busy", 32'(busy), 0);

    // async reset mid-CLEAR at address 7
    frame = 1'b1;
    push_clear(2'b01);
    tick();
    frame = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (fb_we_0 && fb_addr == 16'd7) found = 1'b1;
    end
    check("at7_found", 32'(found), 1);
    check("at7_err", 32'(wr_err), 1);
    rst_n = 1'b0;
    #1;
    check("arst_we", 32'({fb_we_1, fb_we_0}), 0);
    check("arst_front", 32'(fb_front), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_err", 32'(wr_err), 0);
    check("arst_drop", 32'(frames_dropped), 0);
    q.delete();
    #2;
    rst_n = 1'b1;
    tick();

    frame = 1'b1;
    push_clear(2'b01);
    tick();
    frame = 1'b0;
    tick();
    tick();
    check("re_we0", 32'(fb_we_0), 1);
    check("re_addr", 32'(fb_addr), 0);
    repeat (16) tick();
    check("re_done", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
